// File: rtl/rx_crc_check_pkg.sv
// Shared rx CRC-32 definitions: polynomial, seed, good-frame residue and a
// single-byte MSB-first update function used by the lane chain.
package rx_crc_check_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  // Bit 7 of the byte is the first serial bit; no reflection, no final XOR.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  byte_in);
    logic [31:0] c;
    c = crc;
    for (int b = 7; b >= 0; b--) begin
      if (c[31] ^ byte_in[b]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                    c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lane_chain.sv
// Combinational CRC-32 update over LANES byte lanes, lane 0 applied first.
// Disabled lanes pass the running CRC through untouched.
module crc32_lane_chain
  import rx_crc_check_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [31:0]        crc_in,
  input  logic [8*LANES-1:0] data,
  input  logic [LANES-1:0]   keep,
  output logic [31:0]        crc_out
);

  // Each stage owns its own nets so the chain has no shared array to fold back on itself.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] crc_prev;
    logic [31:0] crc_here;

    if (i == 0) begin : g_first
      assign crc_prev = crc_in;
    end else begin : g_next
      assign crc_prev = g_lane[i-1].crc_here;
    end

    assign crc_here = keep[i] ? crc32_byte(crc_prev, data[8*i +: 8]) : crc_prev;
  end

  assign crc_out = g_lane[LANES-1].crc_here;

endmodule

// File: rtl/rx_crc_check.sv
// Streaming rx CRC-32 checker: accumulates a frame including its FCS and
// reports the raw CRC plus a residue verdict. RX_CRC_STATS_EN adds good/bad counters.
module rx_crc_check
  import rx_crc_check_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter logic [31:0] CRC_INIT = CRC32_INIT,
  parameter logic [31:0] RESIDUE  = CRC32_RESIDUE
) (
  input  logic                rxclk,
  input  logic                reset_n,
  input  logic                din_valid,
  input  logic                din_sof,
  input  logic                din_eof,
  input  logic [DATA_W-1:0]   din_data,
  input  logic [DATA_W/8-1:0] din_keep,
  output logic                crc_done,
  output logic                crc_good,
  output logic [31:0]         crc_value,
  output logic                frame_abort
`ifdef RX_CRC_STATS_EN
  ,
  output logic [15:0]         good_cnt,
  output logic [15:0]         bad_cnt
`endif
);

  localparam int LANES = DATA_W / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]  state;
  logic [31:0] crc_reg;
  logic [31:0] crc_seed;
  logic [31:0] crc_next;
  logic        take_beat;
  logic        close_frame;
  logic        abort_frame;

  // A sof beat always restarts from the seed, even when it lands inside an open frame.
  always_comb begin
    crc_seed    = din_sof ? CRC_INIT : crc_reg;
    take_beat   = din_valid && (din_sof || (state == ST_ACCUM));
    close_frame = take_beat && din_eof;
    abort_frame = din_valid && din_sof && (state == ST_ACCUM);
  end

  crc32_lane_chain #(
    .LANES (LANES)
  ) u_chain (
    .crc_in  (crc_seed),
    .data    (din_data),
    .keep    (din_keep),
    .crc_out (crc_next)
  );

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      crc_reg <= CRC_INIT;
    end else if (take_beat) begin
      if (din_eof) begin
        state   <= ST_IDLE;
        crc_reg <= CRC_INIT;
      end else begin
        state   <= ST_ACCUM;
        crc_reg <= crc_next;
      end
    end
  end

  // Result registers: crc_value is held between frames, the pulses last one cycle.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      crc_done    <= 1'b0;
      crc_good    <= 1'b0;
      crc_value   <= 32'h0;
      frame_abort <= 1'b0;
    end else begin
      crc_done    <= close_frame;
      frame_abort <= abort_frame;
      if (close_frame) begin
        crc_value <= crc_next;
        crc_good  <= (crc_next == RESIDUE);
      end
    end
  end

`ifdef RX_CRC_STATS_EN
  // Counters move on the same edge that raises crc_done and stick at all ones.
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt <= 16'h0;
      bad_cnt  <= 16'h0;
    end else if (close_frame) begin
      if (crc_next == RESIDUE) begin
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end else begin
        if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
